// File: rtl/ui_btn_pkg.sv
// Shared button indices, default sizing and press-priority helper for the navigation-button front end.
// Auto-repeat is compiled in only when UI_BTN_AUTOREPEAT_EN is defined.
package ui_btn_pkg;

  localparam int BTN_ENTER = 0;
  localparam int BTN_UP    = 1;
  localparam int BTN_DOWN  = 2;
  localparam int BTN_LEFT  = 3;
  localparam int BTN_RIGHT = 4;

  localparam int N_BTN_DEFAULT = 5;

  localparam logic [N_BTN_DEFAULT-1:0] REPEAT_MASK_DEFAULT =
    N_BTN_DEFAULT'((1 << BTN_UP) | (1 << BTN_DOWN));

  // Priority follows bit index: enter beats up beats down beats left beats right.
  // Returns a one-hot vector holding only the winning request (or zero).
  function automatic logic [31:0] pick_first(input logic [31:0] req);
    return req & (~req + 32'd1);
  endfunction

endpackage

// File: rtl/ui_debounce_cell.sv
// One button: 2-flop synchronizer, debounce counter, press edge detect and optional repeat timer.
// Repeat timer exists only when UI_BTN_AUTOREPEAT_EN is defined and REPEAT_EN is set.
module ui_debounce_cell #(
  parameter int DEBOUNCE_CYCLES = 650000
`ifdef UI_BTN_AUTOREPEAT_EN
  , parameter int REPEAT_DELAY  = 13500000
  , parameter int REPEAT_PERIOD = 4050000
  , parameter bit REPEAT_EN     = 1'b0
`endif
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic level,
  output logic cand
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic          sample;
  logic          stable;
  logic          stable_d;
  logic [CW-1:0] cnt;
  logic          rise;

  // Pins idle high, so the synchronizer resets to the released value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync <= 2'b11;
    end else begin
      sync <= {sync[0], raw};
    end
  end

  assign sample = ~sync[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable   <= 1'b0;
      stable_d <= 1'b0;
      cnt      <= '0;
    end else begin
      stable_d <= stable;
      if (sample == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= ~stable;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign level = stable;
  assign rise  = stable & ~stable_d;

`ifdef UI_BTN_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = (RMAX > 2) ? $clog2(RMAX) : 1;

  if (REPEAT_EN) begin : g_rep
    logic          rep_active;
    logic [RW-1:0] rcnt;
    logic          rep_fire;

    // Counts down to zero; the timer is armed one cycle after the press edge,
    // which is the same cycle the press pulse leaves the top-level register.
    assign rep_fire = rep_active & stable & (rcnt == '0);

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        rep_active <= 1'b0;
        rcnt       <= '0;
      end else if (!stable) begin
        rep_active <= 1'b0;
        rcnt       <= '0;
      end else if (rise) begin
        rep_active <= 1'b1;
        rcnt       <= RW'(REPEAT_DELAY - 1);
      end else if (rep_fire) begin
        rcnt <= RW'(REPEAT_PERIOD - 1);
      end else if (rep_active) begin
        rcnt <= rcnt - RW'(1);
      end
    end

    assign cand = rise | rep_fire;
  end else begin : g_norep
    assign cand = rise;
  end
`else
  assign cand = rise;
`endif

endmodule

// File: rtl/ui_button_conditioner.sv
// Navigation-button front end: per-button debounce cells, fixed-priority arbiter, registered pulses.
// Define UI_BTN_AUTOREPEAT_EN to enable auto-repeat on the buttons selected by REPEAT_MASK.
module ui_button_conditioner
  import ui_btn_pkg::*;
#(
  parameter int               N_BTN           = N_BTN_DEFAULT,
  parameter int               DEBOUNCE_CYCLES = 650000,
  parameter int               REPEAT_DELAY    = 13500000,
  parameter int               REPEAT_PERIOD   = 4050000,
  parameter logic [N_BTN-1:0] REPEAT_MASK     = N_BTN'(REPEAT_MASK_DEFAULT)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_pulse,
  output logic             any_pulse
);

  logic [N_BTN-1:0] cand;
  logic [N_BTN-1:0] grant;

  if (DEBOUNCE_CYCLES < 1 ||
      ((REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) && REPEAT_MASK != '0)) begin : g_bad_cfg
    $error("ui_button_conditioner: timing parameters must be at least 1");
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_cell
    ui_debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef UI_BTN_AUTOREPEAT_EN
      , .REPEAT_DELAY (REPEAT_DELAY)
      , .REPEAT_PERIOD(REPEAT_PERIOD)
      , .REPEAT_EN    (REPEAT_MASK[i])
`endif
    ) u_cell (
      .clk    (clk),
      .reset_n(reset_n),
      .raw    (btn_raw[i]),
      .level  (btn_level[i]),
      .cand   (cand[i])
    );
  end

  // Losing candidates are simply dropped; nothing is queued.
  assign grant = N_BTN'(pick_first(32'(cand)));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_pulse <= '0;
      any_pulse <= 1'b0;
    end else begin
      btn_pulse <= grant;
      any_pulse <= |grant;
    end
  end

endmodule

// File: tb/tb_ui_button_conditioner.sv
// Bench for ui_button_conditioner: directed scenarios plus random pin activity,
// compared every cycle against a behavioural model of the debounce/press/repeat rules.
module tb_ui_button_conditioner;

  localparam int NB = 5;
  localparam int DB = 4;
  localparam int RD = 8;
  localparam int RP = 3;
  localparam logic [NB-1:0] RMASK = 5'b00110;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_pulse;
  logic          any_pulse;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ui_button_conditioner #(
    .N_BTN          (NB),
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP),
    .REPEAT_MASK    (RMASK)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .btn_raw  (btn_raw),
    .btn_level(btn_level),
    .btn_pulse(btn_pulse),
    .any_pulse(any_pulse)
  );

  // Reference model: pins reach the debouncer two edges late; a level flips once the
  // last DB samples all disagree with it; a rising level requests a pulse on the next
  // edge; repeats fall at press_time + RD + n*RP while held; lowest index wins.
  logic [NB-1:0] m_d1, m_d2, m_lvl, m_pend, m_rep_on, exp_pulse;
  logic [DB-1:0] m_hist [NB];
  int            m_t0   [NB];
  int            m_edge;

  always @(posedge clk) begin
    logic [NB-1:0] samp;
    logic [NB-1:0] newp;
    int d;
    if (!reset_n) begin
      m_d1 = '0; m_d2 = '0; m_lvl = '0; m_pend = '0; m_rep_on = '0; exp_pulse = '0;
      for (int b = 0; b < NB; b++) begin
        m_hist[b] = '0;
        m_t0[b]   = 0;
      end
      m_edge = 0;
    end else begin
      exp_pulse = '0;
      for (int b = NB - 1; b >= 0; b--)
        if (m_pend[b]) exp_pulse = NB'(1) << b;
      samp = m_d2;
      m_d2 = m_d1;
      m_d1 = ~btn_raw;
      newp = '0;
      for (int b = 0; b < NB; b++) begin
        m_hist[b] = {m_hist[b][DB-2:0], samp[b]};
        if (m_hist[b] == {DB{~m_lvl[b]}}) begin
          m_lvl[b] = ~m_lvl[b];
          if (m_lvl[b]) begin
            newp[b]     = 1'b1;
            m_rep_on[b] = 1'b1;
            m_t0[b]     = m_edge + 1;
          end
        end
        if (!m_lvl[b]) m_rep_on[b] = 1'b0;
`ifdef UI_BTN_AUTOREPEAT_EN
        if (RMASK[b] && m_rep_on[b] && !newp[b]) begin
          d = m_edge + 1 - m_t0[b];
          if (d >= RD && (d - RD) % RP == 0) newp[b] = 1'b1;
        end
`endif
      end
      m_pend = newp;
      m_edge++;
    end
  end

  task automatic test_reset();
    reset_n = 1'b0;
    btn_raw = '1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (btn_level !== '0 || btn_pulse !== '0 || any_pulse !== 1'b0) begin
        errors++;
        $display("FAIL reset_state level=%b pulse=%b any=%b, want all zero", btn_level, btn_pulse, any_pulse);
      end
    end
    reset_n = 1'b1;
  endtask

  task automatic test_clean_press();
    btn_raw = 5'b11110;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (btn_level !== m_lvl || btn_pulse !== exp_pulse || any_pulse !== |exp_pulse) begin
        errors++;
        $display("FAIL clean_model i=%0d level=%b/%b pulse=%b/%b any=%b", i, btn_level, m_lvl, btn_pulse, exp_pulse, any_pulse);
      end
      if (i == 4 || i == 5 || i == 14 || i == 15) begin
        checks++;
        if (btn_level[0] !== (i == 5 || i == 14)) begin
          errors++;
          $display("FAIL clean_level i=%0d got %b want %b", i, btn_level[0], (i == 5 || i == 14));
        end
      end
      if (i >= 5 && i <= 7) begin
        checks++;
        if (btn_pulse !== ((i == 6) ? 5'b00001 : 5'b00000)) begin
          errors++;
          $display("FAIL clean_pulse i=%0d got %b", i, btn_pulse);
        end
      end
      if (i == 9) btn_raw = '1;
    end
  endtask

  task automatic test_bounce();
    btn_raw = 5'b11101;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      checks++;
      if (btn_level !== 5'b0 || btn_pulse !== 5'b0 || btn_level !== m_lvl || btn_pulse !== exp_pulse) begin
        errors++;
        $display("FAIL bounce i=%0d level=%b pulse=%b want zero", i, btn_level, btn_pulse);
      end
      btn_raw[1] = (i == 2 || i >= 6);
    end
  endtask

  task automatic test_simultaneous();
    btn_raw = 5'b01011;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (btn_level !== m_lvl || btn_pulse !== exp_pulse || any_pulse !== |exp_pulse) begin
        errors++;
        $display("FAIL simul_model i=%0d level=%b/%b pulse=%b/%b", i, btn_level, m_lvl, btn_pulse, exp_pulse);
      end
      if (btn_pulse[4] !== 1'b0) begin
        errors++;
        $display("FAIL simul_bit4 i=%0d got %b want 0", i, btn_pulse[4]);
      end
      if (i == 5) begin
        checks++;
        if (btn_level !== 5'b10100) begin
          errors++;
          $display("FAIL simul_level got %b want 10100", btn_level);
        end
      end
      if (i == 6) begin
        checks++;
        if (btn_pulse !== 5'b00100 || any_pulse !== 1'b1) begin
          errors++;
          $display("FAIL simul_pulse got %b any=%b want 00100", btn_pulse, any_pulse);
        end
      end
      if (i == 9) btn_raw = '1;
    end
  endtask

  // Held from edge 0 to edge 29 (release sampled at edge 30, level falls at edge 35).
  task automatic test_hold(input int b);
    int  seen = 0;
    int  want = 1;
    bit  rep  = 1'b0;
    logic exp_bit;
`ifdef UI_BTN_AUTOREPEAT_EN
    rep = RMASK[b];
`endif
    if (rep)
      for (int k = 6 + RD; k <= 35; k += RP) want++;
    btn_raw = '1;
    btn_raw[b] = 1'b0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      exp_bit = (i == 6) || (rep && i >= 6 + RD && i <= 35 && (i - 6 - RD) % RP == 0);
      checks++;
      if (btn_pulse[b] !== exp_bit || btn_pulse !== exp_pulse || btn_level !== m_lvl) begin
        errors++;
        $display("FAIL hold_btn%0d i=%0d pulse=%b want bit %b model %b", b, i, btn_pulse, exp_bit, exp_pulse);
      end
      if (btn_pulse[b] === 1'b1) seen++;
      if (i == 29) btn_raw = '1;
    end
    checks++;
    if (seen !== want) begin
      errors++;
      $display("FAIL hold_count_btn%0d got %0d pulses want %0d", b, seen, want);
    end
  endtask

  task automatic test_reset_mid_hold();
    btn_raw = 5'b11110;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++;
      if (btn_level !== m_lvl || btn_pulse !== exp_pulse) begin
        errors++;
        $display("FAIL rmid_pre i=%0d level=%b/%b pulse=%b/%b", i, btn_level, m_lvl, btn_pulse, exp_pulse);
      end
    end
    reset_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (btn_level !== 5'b0 || btn_pulse !== 5'b0 || any_pulse !== 1'b0) begin
        errors++;
        $display("FAIL rmid_in_reset i=%0d level=%b pulse=%b any=%b want zero", i, btn_level, btn_pulse, any_pulse);
      end
    end
    reset_n = 1'b1;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      checks++;
      if (i < 12 && (btn_pulse !== ((i == 6) ? 5'b00001 : 5'b00000) || btn_level[0] !== (i >= 5))) begin
        errors++;
        $display("FAIL rmid_after i=%0d pulse=%b level0=%b", i, btn_pulse, btn_level[0]);
      end else if (btn_level !== m_lvl || btn_pulse !== exp_pulse) begin
        errors++;
        $display("FAIL rmid_model i=%0d level=%b/%b pulse=%b/%b", i, btn_level, m_lvl, btn_pulse, exp_pulse);
      end
      if (i == 12) btn_raw = '1;
    end
  endtask

  task automatic test_random();
    int left [NB];
    for (int b = 0; b < NB; b++) left[b] = $urandom_range(1, 12);
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      checks++;
      if (btn_level !== m_lvl || btn_pulse !== exp_pulse || any_pulse !== |exp_pulse) begin
        errors++;
        $display("FAIL random i=%0d level=%b/%b pulse=%b/%b any=%b", i, btn_level, m_lvl, btn_pulse, exp_pulse, any_pulse);
      end
      reset_n = !(i == 400 || i == 401);
      for (int b = 0; b < NB; b++) begin
        left[b]--;
        if (left[b] == 0) begin
          btn_raw[b] = ~btn_raw[b];
          left[b] = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 40) : $urandom_range(1, 8);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_hold(2);
    test_hold(3);
    test_reset_mid_hold();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
